// File: rtl/tm_pkg.sv
// Shared symbols, move encoding and FSM states for the Turing-machine tape unit.
package tm_pkg;

   localparam logic [7:0] BLANK  = 8'h00;
   localparam logic [7:0] LPAREN = 8'h28;
   localparam logic [7:0] RPAREN = 8'h29;
   localparam logic [7:0] SYM_F  = 8'h46;
   localparam logic [7:0] SYM_T  = 8'h54;

   localparam logic MOVE_R = 1'b0;
   localparam logic MOVE_L = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      RUN,
      DONE
   } tm_state_e;

endpackage

// File: rtl/tm_tape_mem.sv
// Tape storage: DEPTH x 8 flop array with async clear, one write port and
// two combinational read ports. Out-of-range addresses read as blank.
module tm_tape_mem
   import tm_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [7:0]    rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [7:0]    rdata_b
);

   logic [7:0] cells [DEPTH];

   // NOTE: the tape must read blank straight after reset, so every cell is
   // cleared here; this forces a flop array rather than a RAM macro.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            cells[i] <= BLANK;
         end
      end else if (we && (32'(waddr) < DEPTH)) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of process order.
         cells[waddr] <= wdata;
      end
   end

   assign rdata_a = (32'(raddr_a) < DEPTH) ? cells[raddr_a] : BLANK;
   assign rdata_b = (32'(raddr_b) < DEPTH) ? cells[raddr_b] : BLANK;

endmodule

// File: rtl/tm_tape.sv
// Tape and head unit for the Turing-machine lab; owns the controller reset.
// Optional step budget enabled by defining TM_TAPE_STEP_LIMIT_EN.
module tm_tape
   import tm_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int AW        = $clog2(DEPTH),
   parameter int MAX_STEPS = 1000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   input  logic          start,
   input  logic [AW-1:0] start_head,
   output logic          tm_reset,
   output logic [7:0]    tm_datain,
   input  logic [7:0]    tm_dataout,
   input  logic          tm_move,
   input  logic          tm_halt,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [AW-1:0] head,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic          timeout,
   output logic [15:0]   steps
);

`ifdef TM_TAPE_STEP_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   localparam logic [AW-1:0] HEAD_MAX  = AW'(DEPTH - 1);
   localparam logic [15:0]   STEP_LAST = 16'(MAX_STEPS - 1);

   tm_state_e     state, state_next;
   logic [AW-1:0] head_q, nh, tape_addr, mem_waddr;
   logic [15:0]   steps_q;
   logic          done_q, overflow_q, timeout_q;
   logic          off_end, limit_hit;
   logic          mem_we;
   logic [7:0]    mem_wdata, tape_sym;
   logic          do_start, do_move, set_done, set_overflow, set_timeout;

   // Candidate head position for this RUN cycle and whether it leaves the tape.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      nh      = head_q + AW'(1);
      off_end = (head_q == HEAD_MAX);
      if (tm_move == MOVE_L) begin
         nh      = head_q - AW'(1);
         off_end = (head_q == '0);
      end
   end

   assign limit_hit = LIMIT_EN && (steps_q == STEP_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      tm_datain    = BLANK;
      tape_addr    = head_q;
      mem_we       = 1'b0;
      mem_waddr    = load_addr;
      mem_wdata    = load_data;
      do_start     = 1'b0;
      do_move      = 1'b0;
      set_done     = 1'b0;
      set_overflow = 1'b0;
      set_timeout  = 1'b0;
      case (state)
         IDLE, DONE: begin
            mem_we = load_en;
            if (start) begin
               do_start   = 1'b1;
               state_next = FIRST;
            end
         end
         FIRST: begin
            tm_datain  = tape_sym;
            state_next = RUN;
         end
         RUN: begin
            // Read ahead at the post-move cell so the controller sees it at the same edge.
            tape_addr = nh;
            tm_datain = tape_sym;
            mem_we    = 1'b1;
            mem_waddr = head_q;
            mem_wdata = tm_dataout;
            if (tm_halt) begin
               set_done   = 1'b1;
               state_next = DONE;
            end else if (off_end) begin
               set_overflow = 1'b1;
               set_done     = 1'b1;
               state_next   = DONE;
            end else begin
               do_move = 1'b1;
               if (limit_hit) begin
                  set_timeout = 1'b1;
                  set_done    = 1'b1;
                  state_next  = DONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q     <= '0;
         steps_q    <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (do_start) begin
         head_q     <= start_head;
         steps_q    <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (state == RUN) begin
         if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
         if (do_move)      head_q     <= nh;
         if (set_done)     done_q     <= 1'b1;
         if (set_overflow) overflow_q <= 1'b1;
         if (set_timeout)  timeout_q  <= 1'b1;
      end
   end

   tm_tape_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .raddr_a (tape_addr),
      .rdata_a (tape_sym),
      .raddr_b (rd_addr),
      .rdata_b (rd_data)
   );

   assign busy     = (state == FIRST) || (state == RUN);
   assign tm_reset = !busy;
   assign head     = head_q;
   assign steps    = steps_q;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign timeout  = timeout_q;

endmodule
